// File: rtl/spi_adc_multich_fifo_wr_pkg.sv
// +--------------------------------------------------------------------+
// | spi_adc_pkg : shared types and helpers for the SPI ADC capture path |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

package spi_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  function automatic int bytes_per_sample(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_adc_multich_fifo_wr_sclk_gen.sv
// +--------------------------------------------------------------------+
// | spi_sclk_gen : clk divider with tick/rise/fall strobes and sclk reg  |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_sclk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic toggle_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  // Strobes flag the edge on which sclk is about to change, not the level.
  assign tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick && toggle_en && !sclk;
  assign fall = tick && toggle_en && sclk;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (!toggle_en)
        sclk <= 1'b0;
      else if (tick)
        sclk <= ~sclk;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_adc_multich_fifo_wr.sv
// +--------------------------------------------------------------------+
// | spi_adc_multich_fifo_wr : multi-channel SPI ADC capture to byte FIFO |
// | Option: define SPI_ADC_CH_TAG_EN to prefix each channel with a tag.  |
// | Revision : 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_adc_multich_fifo_wr
  import spi_adc_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADC_BITS   = 12,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 50
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample,
  input  logic [NUM_CH-1:0] din,
  input  logic              fifo_full,
  output logic              cs_n,
  output logic              sclk,
  output logic              fifo_wr,
  output logic [7:0]        fifo_data,
  output logic              ready,
  output logic              done,
  output logic              overrun
);

  localparam int BPS = bytes_per_sample(ADC_BITS);
`ifdef SPI_ADC_CH_TAG_EN
  localparam int TAG_BYTES = 1;
`else
  localparam int TAG_BYTES = 0;
`endif
  localparam int BYTES_PER_CH = BPS + TAG_BYTES;
  localparam int PADW = 8 * BPS;
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BYW  = (BYTES_PER_CH > 1) ? $clog2(BYTES_PER_CH) : 1;
  localparam int BCW  = $clog2(FRAME_BITS + 1);

  state_t                state;
  logic [CHW-1:0]        ch_idx;
  logic [BYW-1:0]        byte_idx;
  logic [BCW-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0] sr [NUM_CH];

  logic            div_en;
  logic            toggle_en;
  logic            tick;
  logic            rise;
  logic            fall;
  logic [PADW-1:0] padded;
  logic [7:0]      cur_byte;
  logic            last_byte;
  logic            last_in_ch;

  assign div_en    = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign toggle_en = (state == ST_SHIFT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (div_en),
    .toggle_en (toggle_en),
    .tick      (tick),
    .rise      (rise),
    .fall      (fall),
    .sclk      (sclk)
  );

  // All channels shift together; only the low ADC_BITS of the frame are kept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++)
        sr[i] <= '0;
    end else if (rise) begin
      for (int i = 0; i < NUM_CH; i++)
        sr[i] <= {sr[i][FRAME_BITS-2:0], din[i]};
    end
  end

  assign padded     = PADW'(sr[ch_idx][ADC_BITS-1:0]);
  assign last_in_ch = (byte_idx == BYW'(BYTES_PER_CH - 1));
  assign last_byte  = last_in_ch && (ch_idx == CHW'(NUM_CH - 1));

  always_comb begin
    cur_byte = 8'h00;
`ifdef SPI_ADC_CH_TAG_EN
    if (byte_idx == '0)
      cur_byte = {TAG_NIBBLE, 4'(ch_idx)};
    else
      cur_byte = padded[8*(int'(byte_idx) - 1) +: 8];
`else
    cur_byte = padded[8*int'(byte_idx) +: 8];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cs_n      <= 1'b1;
      fifo_wr   <= 1'b0;
      fifo_data <= 8'h00;
      ready     <= 1'b1;
      done      <= 1'b0;
      overrun   <= 1'b0;
      ch_idx    <= '0;
      byte_idx  <= '0;
      bit_cnt   <= '0;
    end else begin
      fifo_wr <= 1'b0;
      done    <= 1'b0;
      overrun <= sample && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (sample) begin
            state   <= ST_SETUP;
            cs_n    <= 1'b0;
            ready   <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ST_SETUP: begin
          if (tick)
            state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (rise)
            bit_cnt <= bit_cnt + BCW'(1);
          if (fall && (bit_cnt == BCW'(FRAME_BITS))) begin
            state <= ST_HOLD;
            cs_n  <= 1'b1;
          end
        end
        ST_HOLD: begin
          ch_idx   <= '0;
          byte_idx <= '0;
          if (tick)
            state <= ST_SEND;
        end
        ST_SEND: begin
          // fifo_data tracks the pending byte, so it stays stable while stalled.
          fifo_data <= cur_byte;
          if (!fifo_full) begin
            fifo_wr <= 1'b1;
            if (last_byte) begin
              state <= ST_DONE;
            end else if (last_in_ch) begin
              byte_idx <= '0;
              ch_idx   <= ch_idx + CHW'(1);
            end else begin
              byte_idx <= byte_idx + BYW'(1);
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cs_n  <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/spi_adc_multich_fifo_wr.md
Name: spi_adc_multich_fifo_wr

Overview:
Parametrised multi-channel SPI ADC capture engine. It is the successor to the single-channel 12-bit reader. One shared cs_n/sclk drives NUM_CH ADCs that shift simultaneously on separate din lines. After a frame, each channel's sample is serialised into bytes and pushed into a downstream byte FIFO with full-flag back-pressure. Everything runs in the system clk domain: sclk is a registered output, never used as an internal clock.

Parameters:
NUM_CH, 2, number of ADC channels (1..16)
ADC_BITS, 12, sample resolution kept from each frame (1..FRAME_BITS)
FRAME_BITS, 16, sclk cycles per conversion frame (2..32)
CLK_DIV, 50, clk cycles per sclk half-period (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
sample  in  1  start-conversion request, sampled in IDLE only
din  in  NUM_CH  serial data, bit i from ADC i
fifo_full  in  1  downstream FIFO full
cs_n  out  1  active-low chip select, shared
sclk  out  1  SPI clock, idle low
fifo_wr  out  1  one-cycle byte write strobe
fifo_data  out  8  byte being written
ready  out  1  high in IDLE
done  out  1  one-cycle pulse when all bytes are written
overrun  out  1  one-cycle pulse when sample is high while busy

Behaviour:
- Reset (sync, reset_n=0 at posedge clk):
  - state=IDLE, cs_n=1, sclk=0, fifo_wr=0, fifo_data=0, done=0, overrun=0, ready=1.
  - Divider counter, bit counter, channel index, byte index and shift registers are cleared.
  - Reset mid-frame or mid-send aborts immediately; partial bytes are not written.
- Byte count: BPS = ceil(ADC_BITS/8) bytes per channel. Total bytes per frame = NUM_CH*BPS (plus tags, see Optional Feature).
- Divider: a counter runs 0..CLK_DIV-1 only outside IDLE/SEND/DONE. Its terminal count is the "tick".
- FSM states: IDLE, SETUP, SHIFT, HOLD, SEND, DONE.
- IDLE:
  - ready=1.
  - sample=1 -> SETUP; cs_n drops to 0 on the same edge.
- SETUP:
  - cs_n=0, sclk=0.
  - Lasts one half-period (CLK_DIV cycles), then -> SHIFT.
- SHIFT:
  - sclk toggles on every tick.
  - On each tick that drives sclk 0->1, every shift reg i takes {sr_i, din[i]} (MSB first).
  - After FRAME_BITS rising edges, the next tick drives sclk to 0 -> HOLD.
- HOLD:
  - cs_n=1.
  - Lasts CLK_DIV cycles; sample_i = sr_i[ADC_BITS-1:0] (LSBs of the frame). -> SEND.
- SEND:
  - Order: channel 0 first; within a channel, least-significant byte first.
  - The top byte is zero-extended to 8 bits.
  - fifo_wr=1 on a cycle only if fifo_full=0. Indices advance only on a write.
  - fifo_full=1 stalls with fifo_wr=0 and holds fifo_data stable. No byte is dropped or duplicated.
  - After the last byte -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Back-to-back: sample held high re-enters SETUP on the cycle after DONE.
- overrun:
  - Pulses on any cycle with sample=1 and state != IDLE.
  - The request is ignored; it is not queued.
- ready=1 only in IDLE. cs_n=0 only in SETUP and SHIFT.
- Latency from sample to first fifo_wr: (2*FRAME_BITS+2)*CLK_DIV + 1 clk cycles, with no back-pressure.

Optional Feature:
Macro SPI_ADC_CH_TAG_EN.
- Defined: before each channel's data bytes, one tag byte {4'hA, ch[3:0]} is written with the same stall rules. Bytes per frame = NUM_CH*(BPS+1).
- Undefined: no tag bytes; byte stream as above.

Decomposition:
- Shared package spi_adc_pkg holds:
  - FSM state enum.
  - Tag nibble constant 4'hA.
  - Function bytes_per_sample(bits).
- One sub-module, spi_sclk_gen: divider plus tick/rise strobes plus sclk register, with an enable input. It is reusable for the DAC path.
- Byte serialiser stays in the top level.

Test Plan:
- NUM_CH=2, ADC_BITS=12, CLK_DIV=2; din0 frame 16'h0ABC, din1 16'h0123, fifo_full=0.
  - Bytes BC,0A,23,01, one per cycle. Then done pulse, then ready=1.
  - First fifo_wr 69 cycles after sample.
- Same setup, fifo_full=1 for 5 cycles after the first write.
  - fifo_wr=0 and fifo_data=0A held for those cycles, then 0A,23,01 resume with no loss.
- sample pulsed during SHIFT -> overrun pulse for 1 cycle; frame completes unaltered; exactly 4 bytes written.
- reset_n=0 for 1 cycle at bit 7 of SHIFT:
  - Next cycle cs_n=1, sclk=0, ready=1, no fifo_wr.
  - A fresh sample then yields a correct full frame.
- ADC_BITS=8, NUM_CH=3, din frames 16'h00FF/16'h0055/16'h0000 -> bytes FF,55,00.
- SPI_ADC_CH_TAG_EN defined, NUM_CH=2, ADC_BITS=12 -> bytes A0,BC,0A,A1,23,01.
